// File: rtl/timer_dev_pkg.sv
// rtl/timer_dev_pkg.sv - register map, CTRL fields, FSM states and bus addresses for timer_dev
package timer_dev_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PS_LO   = 4;
  localparam int CTRL_PS_HI   = 7;

  // Device windows decoded by the CPU-to-device bridge
  localparam logic [31:0] TIMER0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TIMER1_BASE = 32'h0000_7F10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Only 01 reloads; 1x falls back to one-shot
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_dev_if.sv
// rtl/timer_dev_if.sv - bridge-side register bus of timer_dev
interface timer_dev_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, WE, Din, input Dout, IRQ);
  modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped 32-bit down-counting timer with interrupt
// Optional prescaler on CTRL[7:4] enabled by macro TIMER_PRESCALE_EN.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus
);

`ifdef TIMER_PRESCALE_EN
  localparam int CTRL_W = CTRL_PS_HI + 1;
`else
  localparam int CTRL_W = CTRL_IM + 1;
`endif

  logic [CTRL_W-1:0] r_ctrl;
  logic [31:0]       r_preset;
  logic [31:0]       r_count;
  logic              r_irq_pend;
  state_t            r_state;

  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_wr_any;
  logic w_tick;
  logic w_unused;

  assign w_wr_ctrl   = bus.WE && (bus.Addr == REG_CTRL);
  assign w_wr_preset = bus.WE && (bus.Addr == REG_PRESET);
  assign w_wr_any    = w_wr_ctrl || w_wr_preset;
  assign w_unused    = ^bus.Din[31:CTRL_W];

`ifdef TIMER_PRESCALE_EN
  logic [3:0] r_div;

  assign w_tick = (r_div == r_ctrl[CTRL_PS_HI:CTRL_PS_LO]);

  always_ff @(posedge clk) begin
    if (reset || w_wr_any || (r_state == ST_LOAD)) begin
      r_div <= 4'd0;
    end else if ((r_state == ST_CNT) && r_ctrl[CTRL_EN]) begin
      r_div <= w_tick ? 4'd0 : r_div + 4'd1;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // Register writes abort any countdown and win over the FSM in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_preset   <= PRESET_RST;
      r_count    <= 32'd0;
      r_irq_pend <= 1'b0;
      r_state    <= ST_IDLE;
    end else if (w_wr_any) begin
      if (w_wr_ctrl) begin
        r_ctrl <= bus.Din[CTRL_W-1:0];
      end
      if (w_wr_preset) begin
        r_preset <= bus.Din;
      end
      r_irq_pend <= 1'b0;
      r_state    <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_ctrl[CTRL_EN]) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_count <= r_preset;
          r_state <= ST_CNT;
        end
        ST_CNT: begin
          if (!r_ctrl[CTRL_EN]) begin
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            if (r_count > 32'd1) begin
              r_count <= r_count - 32'd1;
            end else begin
              r_count    <= 32'd0;
              r_irq_pend <= 1'b1;
              r_state    <= ST_INT;
            end
          end
        end
        ST_INT: begin
          if (is_reload(r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO])) begin
            r_irq_pend <= 1'b0;
            r_state    <= ST_LOAD;
          end else begin
            r_ctrl[CTRL_EN] <= 1'b0;
            r_state         <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.Dout = 32'd0;
    case (bus.Addr)
      REG_CTRL:   bus.Dout = 32'(r_ctrl);
      REG_PRESET: bus.Dout = r_preset;
      REG_COUNT:  bus.Dout = r_count;
      default:    bus.Dout = 32'd0;
    endcase
  end

  assign bus.IRQ = r_ctrl[CTRL_IM] & r_irq_pend;

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - directed and randomized checks of timer_dev against a timeline model
module tb_timer_dev;

  localparam logic [31:0] RST_P = 32'hDEAD_0007;
`ifdef TIMER_PRESCALE_EN
  localparam logic [31:0] CTRL_MASK = 32'h0000_00FF;
`else
  localparam logic [31:0] CTRL_MASK = 32'h0000_000F;
`endif

  logic clk;
  logic reset;
  timer_dev_if bus();

  timer_dev #(.PRESET_RST(RST_P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: a run starts at the edge where an idle, enabled timer notices Enable.
  // Age a counts edges since then; t=a-1 is time since load. COUNT=N-t/p until
  // T=max(N,1)*p, expiry at t=T, and the following edge ends or restarts the run.
  logic [31:0] m_ctrl, m_preset, m_count;
  logic        m_pend;
  bit          m_active;
  logic [63:0] m_age;

  function automatic logic [63:0] m_period();
`ifdef TIMER_PRESCALE_EN
    return 64'(m_ctrl[7:4]) + 64'd1;
`else
    return 64'd1;
`endif
  endfunction

  always @(posedge clk) begin
    logic [63:0] p, lim, t;
    if (reset) begin
      m_ctrl = 32'd0; m_preset = RST_P; m_count = 32'd0; m_pend = 1'b0; m_active = 1'b0;
    end else if (bus.WE && (bus.Addr == 2'd0 || bus.Addr == 2'd1)) begin
      if (bus.Addr == 2'd0) m_ctrl = bus.Din & CTRL_MASK;
      else m_preset = bus.Din;
      m_active = 1'b0;
      m_pend = 1'b0;
    end else if (m_active) begin
      m_age = m_age + 64'd1;
      p = m_period();
      lim = ((m_preset == 32'd0) ? 64'd1 : 64'(m_preset)) * p;
      t = m_age - 64'd1;
      if (t < lim) begin
        m_count = 32'(64'(m_preset) - t / p);
      end else if (t == lim) begin
        m_count = 32'd0;
        m_pend = 1'b1;
      end else if (m_ctrl[2:1] == 2'b01) begin
        m_pend = 1'b0;
        m_age = 64'd0;
      end else begin
        m_ctrl[0] = 1'b0;
        m_active = 1'b0;
      end
    end else if (m_ctrl[0]) begin
      m_active = 1'b1;
      m_age = 64'd0;
    end
  end

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0: return m_ctrl;
      2'd1: return m_preset;
      2'd2: return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_irq", {31'd0, bus.IRQ}, {31'd0, m_ctrl[3] & m_pend});
      chk("model_dout", bus.Dout, model_read(bus.Addr));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    bus.WE = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = a; bus.Din = d; bus.WE = 1'b1;
    step();
    bus.WE = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] e);
    bus.WE = 1'b0;
    bus.Addr = a;
    #1;
    chk(name, bus.Dout, e);
  endtask

  task automatic irq_chk(input string name, input logic e);
    chk(name, {31'd0, bus.IRQ}, {31'd0, e});
  endtask

  logic        irq_hist [1:12];
  logic [31:0] cnt_hist [1:12];
  logic [31:0] exp_cnt  [2:8];

  task automatic run_hist();
    bus.Addr = 2'd2;
    for (int k = 1; k <= 12; k++) begin
      step();
      irq_hist[k] = bus.IRQ;
      cnt_hist[k] = bus.Dout;
    end
  endtask

  initial begin
    reset = 1'b1; bus.Addr = 2'd0; bus.WE = 1'b0; bus.Din = 32'd0;
    step();
    chk_en = 1'b1;
    step();
    rd_chk("rst_ctrl", 2'd0, 32'd0);
    rd_chk("rst_preset", 2'd1, RST_P);
    rd_chk("rst_count", 2'd2, 32'd0);
    irq_chk("rst_irq", 1'b0);
    reset = 1'b0;
    wr(2'd2, 32'h1234);
    rd_chk("count_ro", 2'd2, 32'd0);
    wr(2'd3, 32'hFFFF_FFFF);
    rd_chk("addr3_zero", 2'd3, 32'd0);

    // one-shot, PRESET=5
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    idle(2); rd_chk("os_e2", 2'd2, 32'd5);
    idle(4); rd_chk("os_e6", 2'd2, 32'd1); irq_chk("os_e6_irq", 1'b0);
    idle(1); rd_chk("os_e7", 2'd2, 32'd0); irq_chk("os_e7_irq", 1'b1);
    idle(1); rd_chk("os_ctrl_autoclr", 2'd0, 32'h8); irq_chk("os_e8_irq", 1'b1);
    idle(3); irq_chk("os_irq_hold", 1'b1);
    wr(2'd0, 32'h8); irq_chk("os_irq_clr", 1'b0);

    // auto-reload, PRESET=3, period 5
    exp_cnt = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3, 32'd2};
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    run_hist();
    for (int k = 1; k <= 12; k++)
      chk($sformatf("ar_irq_%0d", k), {31'd0, irq_hist[k]}, {31'd0, (k == 5 || k == 10)});
    for (int k = 2; k <= 8; k++)
      chk($sformatf("ar_cnt_%0d", k), cnt_hist[k], exp_cnt[k]);
    wr(2'd0, 32'h3);
    run_hist();
    for (int k = 1; k <= 12; k++)
      chk($sformatf("ar_masked_irq_%0d", k), {31'd0, irq_hist[k]}, 32'd0);
    chk("ar_masked_cnt5", cnt_hist[5], 32'd0);
    chk("ar_masked_cnt7", cnt_hist[7], 32'd3);

    // disable mid-count, then restart from a new PRESET
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h1);
    idle(15); rd_chk("mid_cnt7", 2'd2, 32'd7);
    wr(2'd0, 32'h0);
    idle(3); rd_chk("mid_frozen", 2'd2, 32'd7);
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    idle(2); rd_chk("re_e2", 2'd2, 32'd2);
    idle(1); irq_chk("re_e3_irq", 1'b0);
    idle(1); irq_chk("re_e4_irq", 1'b1);

    // CTRL write in the INT cycle beats the one-shot Enable clear
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    idle(3); irq_chk("int_e3_irq", 1'b1);
    wr(2'd0, 32'h9);
    rd_chk("int_wr_ctrl", 2'd0, 32'h9); irq_chk("int_wr_irq", 1'b0);

    // reset mid-count
    wr(2'd1, 32'd50);
    wr(2'd0, 32'hB);
    idle(5);
    reset = 1'b1;
    step();
    rd_chk("midrst_ctrl", 2'd0, 32'd0);
    rd_chk("midrst_preset", 2'd1, RST_P);
    rd_chk("midrst_count", 2'd2, 32'd0);
    irq_chk("midrst_irq", 1'b0);
    reset = 1'b0;
    idle(1);

`ifdef TIMER_PRESCALE_EN
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h39);
    idle(5); rd_chk("ps_e5", 2'd2, 32'd2);
    idle(1); rd_chk("ps_e6", 2'd2, 32'd1);
    idle(3); irq_chk("ps_e9_irq", 1'b0);
    idle(1); irq_chk("ps_e10_irq", 1'b1);
`else
    wr(2'd0, 32'hF9);
    rd_chk("ctrl_mask", 2'd0, 32'h9);
`endif
    wr(2'd0, 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      automatic int r = $urandom_range(0, 99);
      automatic logic [31:0] v = $urandom;
      if (r < 3) begin
        v[0] = ($urandom_range(0, 3) != 0);
        wr(2'd0, v);
      end else if (r < 6) begin
        wr(2'd1, ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 10)));
      end else if (r < 8) begin
        wr(2'($urandom_range(2, 3)), v);
      end else if (r == 8 && $urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else begin
        bus.Addr = 2'($urandom_range(0, 3));
        bus.Din = v;
        idle(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped 32-bit down-counting timer. It is the device instantiated twice behind the CPU-to-device bridge: Timer0 at 0x0000_7F00 and Timer1 at 0x0000_7F10.
- The bridge supplies the word address [3:2], write data and a per-device write enable, and returns this block's read data to the CPU.
- Raises a level/pulse interrupt toward CP0 when the count expires.

Parameters:
- PRESET_RST, 32'h0, reset value of the PRESET register.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Addr  input  2  word select, bridge DEV_Addr[3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=unused
- WE  input  1  write enable (DEV0_WE/DEV1_WE from bridge)
- Din  input  32  write data (DEV_WD)
- Dout  output  32  combinational read data for Addr
- IRQ  output  1  interrupt request to CP0

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high (reset).
- Reset values:
  - CTRL=0, PRESET=PRESET_RST, COUNT=0, state=IDLE, irq_pend=0, IRQ=0.
  - Reset wins over any same-cycle write or count event, including reset asserted mid-count.
- CTRL fields:
  - [0] Enable.
  - [2:1] Mode: 00 = one-shot, 01 = auto-reload, 1x treated as 00.
  - [3] IM, interrupt mask.
  - [31:4] read as 0 (see Optional Feature).
- Reads (combinational, no latency):
  - Addr 0 returns zero-extended CTRL.
  - Addr 1 returns PRESET.
  - Addr 2 returns COUNT.
  - Addr 3 returns 0.
- Writes (WE=1, sampled at the edge):
  - Addr 0 updates CTRL.
  - Addr 1 updates PRESET.
  - Addr 2 and Addr 3 writes are ignored (COUNT is read-only).
  - Any accepted CTRL or PRESET write forces state to IDLE and clears irq_pend at that edge. The write has priority over every FSM action in the same cycle, including the one-shot Enable auto-clear.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if Enable, go to LOAD; else stay. COUNT holds.
  - LOAD: COUNT<=PRESET, go to CNT.
  - CNT:
    - If !Enable, go to IDLE (COUNT frozen).
    - Else if COUNT>1, COUNT<=COUNT-1.
    - Else (COUNT is 1 or 0), COUNT<=0, go to INT, irq_pend<=1.
    - PRESET=0 therefore expires one cycle after LOAD.
  - INT, Mode 00: clear Enable, go to IDLE. irq_pend stays 1 until the next CTRL/PRESET write or reset.
  - INT, Mode 01: go to LOAD. irq_pend is cleared at this edge, so it is high for exactly one cycle per period.
- IRQ = IM & irq_pend. Clearing IM masks the request but does not clear irq_pend.
- Latency: for a CTRL write at edge E0 that sets Enable with PRESET=N≥1, irq_pend rises after edge E0+N+2.
- Auto-reload period: N+2 cycles between IRQ pulses.
- COUNT never wraps below 0. There are no 32-bit boundary issues: PRESET=FFFF_FFFF counts down normally.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- When defined:
  - CTRL[7:4] is a writable, readable prescale field P.
  - In CNT, COUNT decrements (or expires) only when an internal 4-bit divider reaches P.
  - The divider resets to 0 on LOAD, on every decrement, and on any CTRL/PRESET write.
  - Effective tick period is P+1 cycles.
- When undefined:
  - CTRL[7:4] reads 0 and writes are ignored.
  - The divider logic is absent and behaviour is exactly as above.

Decomposition:
- Shared package/header:
  - Register offsets (CTRL=2'd0, PRESET=2'd1, COUNT=2'd2).
  - Mode encodings (MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01).
  - CTRL bit positions.
  - FSM state encodings.
  - Device base addresses 0x7F00 and 0x7F10, also used by the bridge.
- No sub-module: a single flat module (register file, FSM and optional prescaler) is natural at this size.

Test Plan:
- Reset, then read Addr 0/1/2 -> 0 / PRESET_RST / 0. IRQ=0. A write to Addr 2 with 0x1234 leaves COUNT=0.
- PRESET=5, CTRL=0x9 (one-shot, IM, enable) at E0 -> COUNT=5 after E2, 1 after E6, 0 and IRQ=1 after E7. CTRL reads 0x8. IRQ stays high until CTRL is written with 0x8, then drops next edge.
- PRESET=3, CTRL=0xB (auto-reload) -> IRQ one-cycle pulses every 5 cycles, COUNT sequence 3,2,1,0,(reload)3. With CTRL=0x3 (IM=0), IRQ stays 0 while COUNT still cycles.
- Mid-count (COUNT=7), write CTRL=0x0 -> IDLE, COUNT frozen at 7. Write PRESET=2 then CTRL=0x9 -> reload to 2, IRQ after E0+4.
- In a mode-00 INT cycle, write CTRL=0x9 in the same edge -> Enable stays 1 and irq_pend is cleared. Assert reset during CNT -> all registers return to reset values the next edge.
- With TIMER_PRESCALE_EN, CTRL=0x39 (P=3), PRESET=2 -> COUNT decrements every 4 cycles, IRQ after E0+2+2*4.
